fetch_mem_responder: RTL and testbench
======================================

# fetch_mem_responder

Memory-side responder for the datapath's instruction/data memory port. It accepts one word-sized read or write request at a time over a valid/ready handshake and holds it for a fixed latency. It then presents a registered response, which it holds until the requester accepts it. It sits between the datapath's fetch/load-store logic and an internal word-addressed storage array, and replaces the zero-latency combinational memory for multicycle-latency testing.

## Interface
Parameters:
- WIDTH, 32, data and address width in bits.
- DEPTH, 256, number of WIDTH-bit words in the storage array.
- LATENCY, 2, cycles from request accept to response valid; legal range is LATENCY >= 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  WIDTH  byte address.
- req_we  in  1  1 = write, 0 = read.
- req_wdata  in  WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_data  out  WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  request was rejected (see Configuration).

## Operation
- The FSM has three states: IDLE, WAIT and RESP. req_ready = (state == IDLE), decoded combinationally from the state register.
- IDLE:
  - When req_valid && req_ready is sampled high at an edge, latch req_addr, req_we and req_wdata.
  - If LATENCY == 1, go to RESP.
  - Otherwise go to WAIT with the counter loaded to LATENCY-2.
- WAIT:
  - When the counter is 0, go to RESP at the next edge.
  - Otherwise decrement the counter.
- Entry into RESP (same edge):
  - The memory access executes on this edge.
  - A read registers mem[addr[log2(DEPTH)+1:2]] into rsp_data.
  - A write updates the array and registers rsp_data = 0.
  - rsp_err is registered.
- RESP:
  - rsp_valid = 1.
  - rsp_data and rsp_err are held stable until rsp_ready is sampled high.
  - On that edge, go to IDLE and clear rsp_valid, rsp_data and rsp_err.
- A request is not accepted in the same cycle as a response handshake. Peak throughput is one transaction per LATENCY+1 cycles.
- Error check: the request is an error if req_addr[1:0] != 0 or the word index is >= DEPTH.
  - An erroring request returns rsp_err = 1 and rsp_data = 0.
  - A write that errors is suppressed; the array is unchanged.
- The storage array is not reset. Only control state and output registers are reset.

## Timing
- Reset values: state = IDLE, req_ready = 1, rsp_valid = 0, rsp_data = 0, rsp_err = 0, counter = 0.
- Latency: if the accept edge is E0, rsp_valid is high from edge E_LATENCY until the edge where rsp_ready is sampled high.
- Back-pressure: while rsp_ready is low, rsp_valid, rsp_data and rsp_err are unchanged and req_ready stays 0.
- Reset asserted mid-transaction (WAIT or RESP):
  - All outputs return to reset values immediately (asynchronously).
  - The transaction is abandoned.
  - A pending write that has not reached RESP entry never reaches the array.
- req_* inputs are ignored outside IDLE. Their values after the accept edge have no effect.

## Configuration
- Macro FETCH_MEM_ADDR_CHECK_EN.
- Defined: the error check in Operation is compiled in and rsp_err is driven as specified.
- Undefined:
  - No check logic; rsp_err is tied to 0.
  - req_addr[1:0] is ignored and the word index wraps modulo DEPTH. For example, 0x400 with DEPTH = 256 maps to word 0.
  - All writes are performed.

## Test plan
Defaults: WIDTH = 32, DEPTH = 256, LATENCY = 2, rsp_ready = 1, macro defined unless stated.
- Write 0xDEADBEEF to 0x10, then read 0x10 -> read response has rsp_valid high 2 cycles after accept, rsp_data = 0xDEADBEEF, rsp_err = 0; the write response has rsp_data = 0.
- Read 0x10 with rsp_ready held low for 5 cycles after rsp_valid rises -> rsp_valid = 1 and rsp_data = 0xDEADBEEF are stable for all 5 cycles, req_ready = 0 throughout, and IDLE is re-entered one edge after rsp_ready rises.
- req_valid held high for 4 reads -> accepts occur every 3 cycles (LATENCY+1) and exactly 4 responses are returned in order.
- Read 0x13 -> rsp_err = 1, rsp_data = 0. With the macro undefined and mem[4] = 0x1234, the same read returns 0x1234 with rsp_err = 0.
- Write 0xCAFEF00D to 0x400, then read 0x0 -> with the macro defined, the write response has rsp_err = 1 and mem[0] is unchanged; with the macro undefined, the read returns 0xCAFEF00D.
- Assert rst low one cycle after accepting a write of 0x55 to 0x20 (old value 0x11) -> rsp_valid = 0 and req_ready = 1 immediately; after release, a read of 0x20 returns 0x11.

Source files
------------

// File: rtl/fetch_mem_responder.sv
// Word-addressed memory responder with one request in flight and a registered response.
// Latency: response valid LATENCY cycles after the accept cycle; one transaction per LATENCY+1 cycles at best.
// Backpressure: response is held until rsp_ready; no new request is taken until then. FETCH_MEM_ADDR_CHECK_EN enables address checking.
module fetch_mem_responder #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_addr,
    input  logic             req_we,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY >= 2) ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   addr_q;
    logic               we_q;
    logic [WIDTH-1:0]   wdata_q;
    logic [WIDTH-1:0]   rsp_data_q;
    logic               rsp_err_q;

    logic [WIDTH-1:0]   mem [DEPTH];

    // With LATENCY == 1 the access happens on the accept edge, so take the live request.
    logic [WIDTH-1:0]   acc_addr;
    logic               acc_we;
    logic [WIDTH-1:0]   acc_wdata;
    logic [IDX_W-1:0]   acc_idx;
    logic               acc_err;
    logic               mem_en;
    logic               mem_wr;

    assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign acc_we    = (state_q == IDLE) ? req_we    : we_q;
    assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    assign acc_idx   = acc_addr[IDX_W+1:2];

`ifdef FETCH_MEM_ADDR_CHECK_EN
    localparam logic [WIDTH-3:0] DEPTH_W = (WIDTH-2)'(DEPTH);
    assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[WIDTH-1:2] >= DEPTH_W);
`else
    // Low and high address bits are intentionally dropped: the index wraps modulo DEPTH.
    logic unused_addr_bits;
    assign unused_addr_bits = ^acc_addr;
    assign acc_err = 1'b0;
`endif

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign mem_en = (state_d == RESP) && (state_q != RESP);
    // Gated by rst so a clock edge during reset can never commit a write.
    assign mem_wr = mem_en && acc_we && !acc_err && rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && req_valid) begin
                addr_q  <= req_addr;
                we_q    <= req_we;
                wdata_q <= req_wdata;
            end
            if (mem_en) begin
                rsp_data_q <= (acc_we || acc_err) ? '0 : mem[acc_idx];
                rsp_err_q  <= acc_err;
            end else if (state_q == RESP && rsp_ready) begin
                rsp_data_q <= '0;
                rsp_err_q  <= 1'b0;
            end
        end
    end

    // Storage array carries no reset.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

endmodule

// File: tb/tb_fetch_mem_responder.sv
// Randomized self-checking bench for fetch_mem_responder against a word-array reference model.
module tb_fetch_mem_responder;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;
    localparam int TMO     = 50;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [WIDTH-1:0] req_addr = '0;
    logic             req_we = 1'b0;
    logic [WIDTH-1:0] req_wdata = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] ref_mem [DEPTH];
    bit               ref_vld [DEPTH];

    fetch_mem_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    function automatic bit model_err(input logic [WIDTH-1:0] a);
`ifdef FETCH_MEM_ADDR_CHECK_EN
        return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int model_idx(input logic [WIDTH-1:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    // Applies one transaction to the reference array and returns the expected response.
    task automatic model_apply(input logic [WIDTH-1:0] a, input bit we, input logic [WIDTH-1:0] wd,
                               output logic [WIDTH-1:0] exp_data, output bit exp_err);
        exp_err  = model_err(a);
        exp_data = '0;
        if (we) begin
            if (!exp_err) begin
                ref_mem[model_idx(a)] = wd;
                ref_vld[model_idx(a)] = 1'b1;
            end
        end else if (!exp_err) begin
            exp_data = ref_mem[model_idx(a)];
        end
    endtask

    // Drives one request, waits for its response, holds rsp_ready low for 'stall' cycles.
    // Returns when the response handshake edge has passed (#1 after it).
    task automatic do_txn(input logic [WIDTH-1:0] a, input bit we, input logic [WIDTH-1:0] wd,
                          input int stall, output logic [WIDTH-1:0] data, output bit err,
                          output int lat, output bit stable, output bit ok);
        int w;
        ok = 1'b1; stable = 1'b1; lat = 0; data = '0; err = 1'b0;
        rsp_ready = (stall == 0);
        req_addr = a; req_we = we; req_wdata = wd; req_valid = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!req_ready && w < TMO);
        if (!req_ready) ok = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom; req_we = $urandom_range(0, 1);
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < TMO);
        if (!rsp_valid) ok = 1'b0;
        data = rsp_data; err = rsp_err;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== data || rsp_err !== err || req_ready !== 1'b0)
                stable = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        n_checks++; if (rsp_data !== '0) begin n_fail++; $display("FAIL reset_rsp_data got=%h want=0", rsp_data); end
        n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got=%b want=0", rsp_err); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        logic [WIDTH-1:0] d, ed; bit e, ee, st, ok; int lat;
        do_txn(32'h10, 1'b1, 32'hDEADBEEF, 0, d, e, lat, st, ok);
        model_apply(32'h10, 1'b1, 32'hDEADBEEF, ed, ee);
        n_checks++; if (!ok || d !== ed || e !== ee) begin n_fail++; $display("FAIL wr_rsp got=%h/%b want=%h/%b ok=%b", d, e, ed, ee, ok); end
        do_txn(32'h10, 1'b0, '0, 0, d, e, lat, st, ok);
        model_apply(32'h10, 1'b0, '0, ed, ee);
        n_checks++; if (!ok || d !== 32'hDEADBEEF || e !== 1'b0) begin n_fail++; $display("FAIL rd_rsp got=%h/%b want=deadbeef/0 ok=%b", d, e, ok); end
        n_checks++; if (lat !== LATENCY) begin n_fail++; $display("FAIL rd_latency got=%0d want=%0d", lat, LATENCY); end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] d, ed; bit e, ee, st, ok; int lat;
        do_txn(32'h10, 1'b0, '0, 5, d, e, lat, st, ok);
        model_apply(32'h10, 1'b0, '0, ed, ee);
        n_checks++; if (!ok || d !== ed || e !== ee) begin n_fail++; $display("FAIL bp_rsp got=%h/%b want=%h/%b", d, e, ed, ee); end
        n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL bp_stable got=%b want=1", st); end
        n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== '0) begin
            n_fail++; $display("FAIL bp_idle_after req_ready=%b rsp_valid=%b data=%h want 1/0/0", req_ready, rsp_valid, rsp_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] d, ed, exp_q[$], got_q[$]; bit e, ee, st, ok, acc; int lat, n_acc;
        int acc_cyc [4];
        for (int i = 0; i < 4; i++) begin
            do_txn(32'h40 + 4 * i, 1'b1, $urandom, 0, d, e, lat, st, ok);
            model_apply(32'h40 + 4 * i, 1'b1, dut_wd_last(), ed, ee);
        end
        for (int i = 0; i < 4; i++) begin
            model_apply(32'h40 + 4 * i, 1'b0, '0, ed, ee);
            exp_q.push_back(ed);
        end
        n_acc = 0;
        req_we = 1'b0; rsp_ready = 1'b1; req_addr = 32'h40; req_valid = 1'b1;
        for (int c = 0; c < 80 && got_q.size() < 4; c++) begin
            @(negedge clk);
            acc = req_valid && req_ready;
            if (rsp_valid) got_q.push_back(rsp_data);
            @(posedge clk);
            #1;
            if (acc) begin
                acc_cyc[n_acc] = c;
                n_acc++;
                if (n_acc == 4) req_valid = 1'b0;
                else req_addr = 32'h40 + 4 * n_acc;
            end
        end
        req_valid = 1'b0;
        n_checks++; if (n_acc != 4 || got_q.size() != 4) begin n_fail++; $display("FAIL b2b_count accepts=%0d rsps=%0d want 4/4", n_acc, got_q.size()); end
        for (int i = 1; i < n_acc; i++) begin
            n_checks++; if (acc_cyc[i] - acc_cyc[i-1] != LATENCY + 1) begin
                n_fail++; $display("FAIL b2b_gap%0d got=%0d want=%0d", i, acc_cyc[i] - acc_cyc[i-1], LATENCY + 1);
            end
        end
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_data%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    // Write data of the most recent do_txn is reconstructed from the last value driven.
    logic [WIDTH-1:0] last_wd;
    function automatic logic [WIDTH-1:0] dut_wd_last();
        return last_wd;
    endfunction
    always @(posedge clk) if (req_valid && req_ready) last_wd <= req_wdata;

    task automatic test_addr_error();
        logic [WIDTH-1:0] d, ed; bit e, ee, st, ok; int lat;
        do_txn(32'h10, 1'b1, 32'h1234, 0, d, e, lat, st, ok);
        model_apply(32'h10, 1'b1, 32'h1234, ed, ee);
        do_txn(32'h13, 1'b0, '0, 0, d, e, lat, st, ok);
        model_apply(32'h13, 1'b0, '0, ed, ee);
        n_checks++; if (!ok || d !== ed || e !== ee) begin n_fail++; $display("FAIL misaligned_rd got=%h/%b want=%h/%b", d, e, ed, ee); end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] d, ed, seed; bit e, ee, st, ok; int lat;
        seed = 32'hA5A50000 | ($urandom & 32'hFFFF);
        do_txn(32'h0, 1'b1, seed, 0, d, e, lat, st, ok);
        model_apply(32'h0, 1'b1, seed, ed, ee);
        do_txn(32'h400, 1'b1, 32'hCAFEF00D, 0, d, e, lat, st, ok);
        model_apply(32'h400, 1'b1, 32'hCAFEF00D, ed, ee);
        n_checks++; if (!ok || d !== '0 || e !== ee) begin n_fail++; $display("FAIL wrap_wr got=%h/%b want=0/%b", d, e, ee); end
        do_txn(32'h0, 1'b0, '0, 0, d, e, lat, st, ok);
        model_apply(32'h0, 1'b0, '0, ed, ee);
        n_checks++; if (!ok || d !== ed || e !== ee) begin n_fail++; $display("FAIL wrap_rd got=%h/%b want=%h/%b", d, e, ed, ee); end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a, wd, d, ed; bit we, e, ee, st, ok; int lat, k;
        for (int t = 0; t < 40; t++) begin
            k = $urandom_range(0, 99);
            if (k < 70)      a = 32'h100 + 4 * $urandom_range(0, 15);
            else if (k < 85) a = 32'h100 + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
            else             a = 32'h400 + 4 * $urandom_range(0, 15);
            we = $urandom_range(0, 1);
            if (!we && !model_err(a) && !ref_vld[model_idx(a)]) we = 1'b1;
            wd = $urandom;
            do_txn(a, we, wd, $urandom_range(0, 3), d, e, lat, st, ok);
            model_apply(a, we, wd, ed, ee);
            n_checks++; if (!ok || d !== ed || e !== ee || lat != LATENCY || !st) begin
                n_fail++; $display("FAIL rand%0d addr=%h we=%b got=%h/%b lat=%0d st=%b want=%h/%b lat=%0d", t, a, we, d, e, lat, st, ed, ee, LATENCY);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [WIDTH-1:0] d, ed; bit e, ee, st, ok; int lat, w;
        do_txn(32'h20, 1'b1, 32'h11, 0, d, e, lat, st, ok);
        model_apply(32'h20, 1'b1, 32'h11, ed, ee);
        req_addr = 32'h20; req_we = 1'b1; req_wdata = 32'h55; req_valid = 1'b1; rsp_ready = 1'b1;
        w = 0;
        do begin @(negedge clk); w++; end while (!req_ready && w < TMO);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL midrst_outputs rsp_valid=%b req_ready=%b want 0/1", rsp_valid, req_ready);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_txn(32'h20, 1'b0, '0, 0, d, e, lat, st, ok);
        n_checks++; if (!ok || d !== 32'h11 || e !== 1'b0) begin n_fail++; $display("FAIL midrst_rd got=%h/%b want=00000011/0", d, e); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_vld[i] = 1'b0;
        test_reset();
        test_write_read();
        test_backpressure();
        test_back_to_back();
        test_addr_error();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
